// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM encoding, grant identifiers and the default access timeout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IF = 2'd1,
        ST_GRANT_D  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for a granted access: cleared on clr, counts on en, flags the last allowed cycle.
// Latency: expired is a combinational decode of the registered count; no backpressure.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Grant one cycle after request; ack/err one cycle after mem_ack/timeout; requesters hold req until ack/err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    state_t      state_q, state_d;
    gnt_t        last_q, last_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        if_elig, d_elig, expired;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clr     (state_q == ST_IDLE),
        .en      ((state_q != ST_IDLE) && !mem_ack),
        .expired (expired)
    );

    // A requester whose completion is visible this cycle is still holding req; don't re-grant it.
    assign if_elig = if_req && !if_ack_q && !if_err_q;
    assign d_elig  = d_req && !d_ack_q && !d_err_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_elig && (!d_elig || last_q == GNT_D)) begin
                    state_d     = ST_GRANT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 64'd0;
                end else if (d_elig) begin
                    state_d     = ST_GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            ST_GRANT_IF: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata[31:0];
                    last_d     = GNT_IF;
                end else if (expired) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if_err_d  = 1'b1;
                    last_d    = GNT_IF;
                end
            end
            ST_GRANT_D: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = mem_rdata;
                    last_d    = GNT_D;
                end else if (expired) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    d_err_d   = 1'b1;
                    last_d    = GNT_D;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Reset leaves last grant at IF so the first tie goes to data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle timeout.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic        d_ack, d_err;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] RD_A = 64'h1111_2222_3333_4444;
    localparam logic [63:0] RD_B = 64'h5555_6666_7777_8888;
    localparam logic [63:0] RD_C = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] RD_D = 64'hCAFE_F00D_0123_4567;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_resp"}, {60'd0, if_ack, if_err, d_ack, d_err}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 64'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
        mem_rdata = 64'd0; mem_ack = 1'b0;
        #2;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_rdata", {if_rdata, d_rdata[31:0]}, 64'd0);
        chk_quiet("rst");
        tick(); tick();
        reset = 1'b0;

        // Fetch only: grant, two wait cycles, ack on the third.
        if_req = 1'b1; if_addr = 64'h40;
        tick();
        chk("f_c1_req", {63'd0, mem_req}, 64'd1);
        chk("f_c1_addr", mem_addr, 64'h40);
        chk("f_c1_we_wd", {63'd0, mem_we} | mem_wdata, 64'd0);
        tick();
        chk("f_c2_req", {63'd0, mem_req}, 64'd1);
        tick();
        chk("f_c3_req", {63'd0, mem_req}, 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h0000_0000_00A3_0023;
        tick();
        chk("f_ack", {62'd0, if_ack, mem_req}, 64'h2);
        chk("f_rdata", {32'd0, if_rdata}, 64'h00A3_0023);
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
        tick();
        chk_quiet("f_after");
        chk("f_hold", {32'd0, if_rdata}, 64'h00A3_0023);

        // Tie: D first (last grant IF), then alternation with both held.
        if_req = 1'b1; if_addr = 64'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        tick();
        chk("tie1_addr", mem_addr, 64'h300);
        mem_ack = 1'b1; mem_rdata = RD_A;
        tick();
        chk("tie1_dack", {62'd0, d_ack, mem_req}, 64'h2);
        chk("tie1_drd", d_rdata, RD_A);
        mem_ack = 1'b0;
        tick();
        chk("tie2_req", {63'd0, mem_req}, 64'd1);
        chk("tie2_addr", mem_addr, 64'h200);
        mem_ack = 1'b1; mem_rdata = RD_B;
        tick();
        chk("tie2_iack", {61'd0, if_ack, d_ack, mem_req}, 64'h4);
        chk("tie2_ird", {32'd0, if_rdata}, {32'd0, RD_B[31:0]});
        chk("tie2_dhold", d_rdata, RD_A);
        mem_ack = 1'b0;
        tick();
        chk("tie3_addr", mem_addr, 64'h300);
        mem_ack = 1'b1; mem_rdata = RD_C;
        tick();
        chk("tie3_dack", {63'd0, d_ack}, 64'd1);
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("tie_idle", {63'd0, mem_req}, 64'd0);

        // Store with inputs perturbed mid-access, req held through ack.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF;
        tick();
        chk("st_we", {62'd0, mem_we, mem_req}, 64'h3);
        d_we = 1'b0; d_addr = 64'h999; d_wdata = 64'h1234;
        tick();
        chk("st_addr", mem_addr, 64'h100);
        chk("st_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("st_we_stable", {63'd0, mem_we}, 64'd1);
        mem_ack = 1'b1;
        tick();
        chk("st_dack", {62'd0, d_ack, mem_req}, 64'h2);
        mem_ack = 1'b0;
        tick();
        chk("held_no_regrant", {63'd0, mem_req}, 64'd0);
        chk_quiet("held");
        d_req = 1'b0; mem_ack = 1'b1;
        tick();
        chk_quiet("stray");
        chk("stray_req", {63'd0, mem_req}, 64'd0);
        mem_ack = 1'b0;

        // Timeout: four request cycles then d_err, data held.
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_c%0d_req", i), {63'd0, mem_req}, 64'd1);
        end
        tick();
        chk("to_err", {61'd0, mem_req, d_ack, d_err}, 64'h1);
        chk("to_drd_hold", d_rdata, RD_C);
        d_req = 1'b0;
        tick();
        chk_quiet("to_after");

        // Ack on the final allowed cycle wins over timeout.
        d_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ta_c%0d_req", i), {63'd0, mem_req}, 64'd1);
        end
        mem_ack = 1'b1; mem_rdata = RD_D;
        tick();
        chk("ta_ack", {61'd0, mem_req, d_ack, d_err}, 64'h2);
        chk("ta_drd", d_rdata, RD_D);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Reset in the middle of a fetch.
        if_req = 1'b1; if_addr = 64'h700;
        tick();
        chk("rm_req", {63'd0, mem_req}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rm_req_drop", {63'd0, mem_req}, 64'd0);
        chk("rm_addr", mem_addr, 64'd0);
        chk("rm_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
        tick();
        reset = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = RD_A;
        tick();
        chk_quiet("rm_late");
        chk("rm_late_req", {63'd0, mem_req}, 64'd0);
        mem_ack = 1'b0;
        tick();
        chk_quiet("rm_after");

        // After reset the first tie again goes to D.
        if_req = 1'b1; d_req = 1'b1; if_addr = 64'h800; d_addr = 64'h900;
        tick();
        chk("rt_addr", mem_addr, 64'h900);
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1;
        tick();
        chk("rt_dack", {63'd0, d_ack}, 64'd1);
        mem_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
